uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single UART transmitter among `N_REQ` byte-stream requesters (CPU console, debug tracer, DMA log, etc.). It sits between the requesters and the UART core's write port (`wr_uart`, `w_data`, `tx_full`). A granted requester holds the UART until its packet ends (`req_last`), so multi-byte messages never interleave. An inactivity timeout reclaims the UART from a stalled owner.

---
 rtl/uart_arb_pkg.sv | 35 +++
 rtl/rr_select.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
// Holds the FSM state enum, the requester limit and the round-robin pick.
package uart_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int N_REQ_MAX = 8;
  localparam int PTR_W     = $clog2(N_REQ_MAX);

  // First set bit of req at or after ptr, wrapping over N_REQ_MAX.
  // Unused upper bits of req must be zero, so wrapping over the
  // full width equals wrapping modulo the real requester count.
  function automatic logic [PTR_W-1:0] rr_next(
    input logic [PTR_W-1:0]     ptr,
    input logic [N_REQ_MAX-1:0] req
  );
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] sel;
    logic             found;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ_MAX; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector, reusable for slot arbiters.
// In: rr_ptr, req_valid. Out: sel (winner index), any (some request).
module rr_select
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     any
);

  localparam int W = $clog2(N_REQ);

  logic [N_REQ_MAX-1:0] req_pad;
  logic [PTR_W-1:0]     ptr_pad;

  always_comb begin
    req_pad            = '0;
    req_pad[N_REQ-1:0] = req_valid;
    ptr_pad            = '0;
    ptr_pad[W-1:0]     = rr_ptr;
  end

  assign sel = W'(rr_next(ptr_pad, req_pad));
  assign any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of a UART TX write port.
// Ports: clk, reset (async, active-low); req_valid/req_data/req_last/
// req_ready per requester; tx_full in; wr_uart, w_data to the UART;
// grant_id, busy, timeout_evt status.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*8-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     tx_full,
  output logic                     wr_uart,
  output logic [7:0]               w_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_evt
);

  localparam int W  = $clog2(N_REQ);
  localparam int CW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [W-1:0]  LAST_ID = W'(N_REQ - 1);
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT_CYC);

  arb_state_t    state;
  logic [W-1:0]  rr_ptr;
  logic [W-1:0]  sel;
  logic [W-1:0]  ptr_inc;
  logic [CW-1:0] cnt;
  logic          any;
  logic          own_valid;
  logic          xfer;
  logic          expire;

  rr_select #(
    .N_REQ(N_REQ)
  ) u_sel (
    .rr_ptr   (rr_ptr),
    .req_valid(req_valid),
    .sel      (sel),
    .any      (any)
  );

  assign busy      = (state == LOCK);
  assign own_valid = req_valid[grant_id];
  assign xfer      = busy && own_valid && !tx_full;
  assign wr_uart   = xfer;
  assign ptr_inc   = (grant_id == LAST_ID) ?
                     '0 : grant_id + 1'b1;

  // A transfer in the expiry cycle keeps the grant.
  assign expire = TO_EN && busy && !xfer &&
                  (cnt == TO_VAL);

  always_comb begin
    req_ready = '0;
    if (busy && !tx_full) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    w_data = 8'h00;
    if (busy) w_data = req_data[8*int'(grant_id) +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_id <= sel;
            cnt      <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (xfer) begin
            cnt <= '0;
            if (req_last[grant_id]) begin
              rr_ptr <= ptr_inc;
              state  <= IDLE;
            end
          end else if (expire) begin
            cnt         <= '0;
            rr_ptr      <= ptr_inc;
            timeout_evt <= 1'b1;
            state       <= IDLE;
          end else if (!own_valid && TO_EN) begin
            // tx_full stalls with valid high do not count
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter.
// Two instances: timeout 16 (main) and timeout disabled.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        tx_full;

  logic [3:0]  rdy;
  logic        wr;
  logic [7:0]  wd;
  logic [1:0]  gid;
  logic        busy;
  logic        evt;

  logic [3:0]  rdy0;
  logic        wr0;
  logic [7:0]  wd0;
  logic [1:0]  gid0;
  logic        busy0;
  logic        evt0;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy),
    .tx_full(tx_full), .wr_uart(wr), .w_data(wd),
    .grant_id(gid), .busy(busy), .timeout_evt(evt)
  );

  uart_tx_arbiter #(
    .N_REQ(4), .TIMEOUT_CYC(0)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(rdy0),
    .tx_full(tx_full), .wr_uart(wr0), .w_data(wd0),
    .grant_id(gid0), .busy(busy0), .timeout_evt(evt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_full   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_full   = 1'b0;
    #2;
    vec++;
    if ({rdy, wr, wd, gid, busy, evt} !== 17'd0) begin
      err++;
      $display("FAIL reset_outs got=%h exp=0",
               {rdy, wr, wd, gid, busy, evt});
    end
    vec++;
    if ({rdy0, wr0, wd0, gid0, busy0, evt0} !== 17'd0) begin
      err++;
      $display("FAIL reset_outs0 got=%h exp=0",
               {rdy0, wr0, wd0, gid0, busy0, evt0});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    vec++;
    if ({busy, wr, gid} !== 4'd0) begin
      err++;
      $display("FAIL post_reset_idle got=%b exp=0",
               {busy, wr, gid});
    end
  endtask

  task automatic test_two_packets();
    do_reset();
    // t0
    req_valid     = 4'b1010;
    req_data[15:8]  = 8'hA1;
    req_data[31:24] = 8'hC1;
    #1;
    vec++;
    if (busy !== 1'b0 || wr !== 1'b0) begin
      err++;
      $display("FAIL tp_t0 busy=%b wr=%b exp 0 0", busy, wr);
    end
    tick(); // t1
    #1;
    vec++;
    if ({wr, wd, gid, rdy} !== {1'b1, 8'hA1, 2'd1, 4'b0010}) begin
      err++;
      $display("FAIL tp_t1 wr=%b wd=%h gid=%0d rdy=%b exp 1 a1 1 0010",
               wr, wd, gid, rdy);
    end
    tick(); // t2
    req_data[15:8] = 8'hA2;
    req_last[1]    = 1'b1;
    #1;
    vec++;
    if ({wr, wd, gid} !== {1'b1, 8'hA2, 2'd1}) begin
      err++;
      $display("FAIL tp_t2 wr=%b wd=%h gid=%0d exp 1 a2 1",
               wr, wd, gid);
    end
    tick(); // t3
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    #1;
    vec++;
    if (wr !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL tp_t3 wr=%b busy=%b exp 0 0", wr, busy);
    end
    tick(); // t4
    #1;
    vec++;
    if ({wr, wd, gid} !== {1'b1, 8'hC1, 2'd3}) begin
      err++;
      $display("FAIL tp_t4 wr=%b wd=%h gid=%0d exp 1 c1 3",
               wr, wd, gid);
    end
    tick(); // t5
    req_data[31:24] = 8'hC2;
    req_last[3]     = 1'b1;
    #1;
    vec++;
    if ({wr, wd, gid} !== {1'b1, 8'hC2, 2'd3}) begin
      err++;
      $display("FAIL tp_t5 wr=%b wd=%h gid=%0d exp 1 c2 3",
               wr, wd, gid);
    end
    tick(); // t6
    req_valid = '0;
    req_last  = '0;
    #1;
    vec++;
    if (busy !== 1'b0 || gid !== 2'd3) begin
      err++;
      $display("FAIL tp_hold busy=%b gid=%0d exp 0 3", busy, gid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      vec++;
      if ({busy, wr, gid, wd} !==
          {1'b1, 1'b1, 2'(k % 4), 8'(8'h10 + k % 4)}) begin
        err++;
        $display("FAIL rr_grant%0d busy=%b wr=%b gid=%0d wd=%h exp gid %0d",
                 k, busy, wr, gid, wd, k % 4);
      end
      tick();
      #1;
      vec++;
      if (busy !== 1'b0) begin
        err++;
        $display("FAIL rr_gap%0d busy=%b exp 0", k, busy);
      end
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_tx_full_stall();
    do_reset();
    req_valid[2]    = 1'b1;
    req_last[2]     = 1'b1;
    req_data[23:16] = 8'h5A;
    tx_full         = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      #1;
      vec++;
      if ({busy, gid, rdy, wr, evt} !==
          {1'b1, 2'd2, 4'b0000, 1'b0, 1'b0}) begin
        err++;
        $display("FAIL stall_c%0d busy=%b gid=%0d rdy=%b wr=%b evt=%b",
                 i, busy, gid, rdy, wr, evt);
      end
    end
    tick();
    tx_full = 1'b0;
    #1;
    vec++;
    if ({wr, wd, rdy} !== {1'b1, 8'h5A, 4'b0100}) begin
      err++;
      $display("FAIL stall_release wr=%b wd=%h rdy=%b exp 1 5a 0100",
               wr, wd, rdy);
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    vec++;
    if (busy !== 1'b0 || evt !== 1'b0) begin
      err++;
      $display("FAIL stall_done busy=%b evt=%b exp 0 0", busy, evt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid      = 4'b0011;
    req_last       = 4'b0010;
    req_data[7:0]  = 8'h33;
    req_data[15:8] = 8'h44;
    tick(); // t1
    #1;
    vec++;
    if ({wr, wd, gid, rdy} !== {1'b1, 8'h33, 2'd0, 4'b0001}) begin
      err++;
      $display("FAIL to_first wr=%b wd=%h gid=%0d rdy=%b exp 1 33 0 0001",
               wr, wd, gid, rdy);
    end
    tick(); // t2
    req_valid[0] = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b1 || wr !== 1'b0) begin
      err++;
      $display("FAIL to_t2 busy=%b wr=%b exp 1 0", busy, wr);
    end
    for (int c = 3; c <= 18; c++) begin
      tick();
      #1;
      vec++;
      if (busy !== 1'b1 || evt !== 1'b0) begin
        err++;
        $display("FAIL to_wait_t%0d busy=%b evt=%b exp 1 0",
                 c, busy, evt);
      end
    end
    tick(); // t19
    #1;
    vec++;
    if ({busy, evt} !== 2'b01) begin
      err++;
      $display("FAIL to_fire busy=%b evt=%b exp 0 1", busy, evt);
    end
    tick(); // t20
    #1;
    vec++;
    if ({evt, busy, gid, wr, wd} !==
        {1'b0, 1'b1, 2'd1, 1'b1, 8'h44}) begin
      err++;
      $display("FAIL to_next evt=%b busy=%b gid=%0d wr=%b wd=%h exp 0 1 1 1 44",
               evt, busy, gid, wr, wd);
    end
    tick();
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_expiry_race();
    do_reset();
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h61;
    tick(); // t1
    #1;
    vec++;
    if (wr !== 1'b1) begin
      err++;
      $display("FAIL race_first wr=%b exp 1", wr);
    end
    tick(); // t2
    req_valid[0] = 1'b0;
    for (int c = 3; c <= 17; c++) tick();
    tick(); // t18: counter at limit
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h62;
    #1;
    vec++;
    if ({busy, wr, wd} !== {1'b1, 1'b1, 8'h62}) begin
      err++;
      $display("FAIL race_xfer busy=%b wr=%b wd=%h exp 1 1 62",
               busy, wr, wd);
    end
    tick(); // t19
    req_data[7:0] = 8'h63;
    req_last[0]   = 1'b1;
    #1;
    vec++;
    if ({busy, evt, wr} !== 3'b101) begin
      err++;
      $display("FAIL race_kept busy=%b evt=%b wr=%b exp 1 0 1",
               busy, evt, wr);
    end
    tick(); // t20
    req_valid = '0;
    req_last  = '0;
    #1;
    vec++;
    if ({busy, evt} !== 2'b00) begin
      err++;
      $display("FAIL race_end busy=%b evt=%b exp 0 0", busy, evt);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid[0]  = 1'b1;
    req_last[0]   = 1'b1;
    req_data[7:0] = 8'h01;
    tick(); // t1: req0 one-byte packet, rr_ptr -> 1
    tick(); // t2
    req_valid = 4'b0100;
    req_last  = '0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      req_data[23:16] = 8'(8'hB0 + k);
      #1;
      vec++;
      if ({wr, gid, wd} !== {1'b1, 2'd2, 8'(8'hB0 + k)}) begin
        err++;
        $display("FAIL rmid_byte%0d wr=%b gid=%0d wd=%h", k, wr, gid, wd);
      end
    end
    reset = 1'b0;
    #1;
    vec++;
    if ({rdy, wr, wd, gid, busy, evt} !== 17'd0) begin
      err++;
      $display("FAIL rmid_clear got=%h exp=0",
               {rdy, wr, wd, gid, busy, evt});
    end
    req_valid = 4'b0101;
    req_last  = 4'b0101;
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    #1;
    vec++;
    if ({busy, gid, wr, wd} !== {1'b1, 2'd0, 1'b1, 8'h01}) begin
      err++;
      $display("FAIL rmid_restart busy=%b gid=%0d wr=%b wd=%h exp 1 0 1 01",
               busy, gid, wr, wd);
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  task automatic test_timeout_disabled();
    do_reset();
    req_valid[1]   = 1'b1;
    req_data[15:8] = 8'h77;
    tick(); // t1
    #1;
    vec++;
    if ({busy0, gid0, wr0} !== {1'b1, 2'd1, 1'b1}) begin
      err++;
      $display("FAIL nto_first busy=%b gid=%0d wr=%b exp 1 1 1",
               busy0, gid0, wr0);
    end
    tick();
    req_valid[1] = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      tick();
      vec++;
      if (busy0 !== 1'b1 || evt0 !== 1'b0) begin
        err++;
        $display("FAIL nto_hold_c%0d busy=%b evt=%b exp 1 0",
                 c, busy0, evt0);
      end
    end
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b1;
    #1;
    vec++;
    if ({wr0, wd0, gid0} !== {1'b1, 8'h77, 2'd1}) begin
      err++;
      $display("FAIL nto_resume wr=%b wd=%h gid=%0d exp 1 77 1",
               wr0, wd0, gid0);
    end
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    vec++;
    if (busy0 !== 1'b0 || evt0 !== 1'b0) begin
      err++;
      $display("FAIL nto_end busy=%b evt=%b exp 0 0", busy0, evt0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_packets();
    test_round_robin();
    test_tx_full_stall();
    test_timeout();
    test_expiry_race();
    test_reset_mid_packet();
    test_timeout_disabled();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
